// File: rtl/vdic_serial_alu_pkg.sv
// Shared types, constants and word helpers for the vdic_serial_alu block.
// VDIC_SERIAL_ALU_MUL_EN enables the multiply command (0x08).
package vdic_serial_alu_pkg;

    localparam int WORD_W = 10;

    typedef enum logic [7:0] {
        OP_AND = 8'h01,
        OP_OR  = 8'h02,
        OP_XOR = 8'h04,
        OP_MUL = 8'h08,
        OP_ADD = 8'h10,
        OP_SUB = 8'h20
    } operation_t;

    typedef enum logic {
        PT_DATA    = 1'b0,
        PT_CONTROL = 1'b1
    } payload_type_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMPUTE,
        S_SEND
    } state_t;

    localparam int STAT_INVALID = 7;
    localparam int STAT_PARITY  = 6;
    localparam int STAT_COUNT   = 5;

    // Parity bit that makes the whole 10-bit word even.
    function automatic logic word_parity(logic [8:0] payload);
        return ^payload;
    endfunction

    function automatic logic [WORD_W-1:0] encode_word(payload_type_t t, logic [7:0] b);
        return {t, b, word_parity({t, b})};
    endfunction

    function automatic logic op_valid(logic [7:0] op);
        logic ok;
        ok = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) ||
             (op == OP_ADD) || (op == OP_SUB);
`ifdef VDIC_SERIAL_ALU_MUL_EN
        ok = ok || (op == OP_MUL);
`else
        ok = ok && 1'b1;
`endif
        return ok;
    endfunction

endpackage

// File: rtl/vdic_serial_word_rx.sv
// Serial word receiver: shifts din MSB first while enabled and presents each
// completed 10-bit word for one cycle with its type, byte and parity status.
module vdic_serial_word_rx
    import vdic_serial_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en_i,
    input  logic       enable_n_i,
    input  logic       din_i,
    output logic       word_valid_o,
    output logic       word_type_o,
    output logic [7:0] word_byte_o,
    output logic       parity_ok_o
);

    logic [8:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_q, word_d;

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (!rx_en_i || enable_n_i) begin
            bit_cnt_d = 4'd0;
        end else if (bit_cnt_q == 4'd9) begin
            word_d       = {shift_q, din_i};
            word_valid_d = 1'b1;
            bit_cnt_d    = 4'd0;
        end else begin
            shift_d   = {shift_q[7:0], din_i};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_type_o  = word_q[9];
    assign word_byte_o  = word_q[8:1];
    assign parity_ok_o  = (word_parity(word_q[9:1]) == word_q[0]);

endmodule

// File: rtl/vdic_serial_alu.sv
// Serial ALU: receives a frame of operands plus a command word, folds the
// operation over the operands and returns a status word and result words.
// Define VDIC_SERIAL_ALU_MUL_EN to enable the multiply command.
module vdic_serial_alu
    import vdic_serial_alu_pkg::*;
#(
    parameter int MAX_OPERANDS = 9,
    parameter int RESULT_BYTES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_n,
    input  logic din,
    output logic dout,
    output logic dout_valid
);

    localparam int RW      = 8 * RESULT_BYTES;
    localparam int FRAME_W = WORD_W * (1 + RESULT_BYTES);
    localparam int CNT_W   = $clog2(MAX_OPERANDS + 1);
    localparam int IDX_W   = $clog2(MAX_OPERANDS);
    localparam int TXC_W   = $clog2(FRAME_W + 1);

    logic       rx_valid, rx_type, rx_parity_ok;
    logic [7:0] rx_byte;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, idx_q, idx_d;
    logic               par_err_q, par_err_d, cnt_err_q, cnt_err_d;
    logic [7:0]         op_q, op_d, status_q, status_d;
    logic [RW-1:0]      acc_q, acc_d, acc_next, result;
    logic [FRAME_W-1:0] tx_q, tx_d, frame;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               dout_q, dout_d, dout_valid_q, dout_valid_d;
    logic               buf_we, load_tx;
    logic [7:0]         buffer_q [2**IDX_W];

    vdic_serial_word_rx u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_en_i      ((state_q == S_IDLE) || (state_q == S_RECV)),
        .enable_n_i   (enable_n),
        .din_i        (din),
        .word_valid_o (rx_valid),
        .word_type_o  (rx_type),
        .word_byte_o  (rx_byte),
        .parity_ok_o  (rx_parity_ok)
    );

    function automatic logic [RW-1:0] fold(logic [RW-1:0] acc, logic [7:0] opnd, logic [7:0] op);
        logic [RW-1:0] b;
        b = RW'(opnd);
        case (op)
            OP_ADD:  fold = acc + b;
            OP_SUB:  fold = acc - b;
            OP_AND:  fold = acc & b;
            OP_OR:   fold = acc | b;
            OP_XOR:  fold = acc ^ b;
`ifdef VDIC_SERIAL_ALU_MUL_EN
            OP_MUL:  fold = acc * b;
`endif
            default: fold = acc;
        endcase
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(logic [7:0] status, logic [RW-1:0] res);
        build_frame = '0;
        build_frame[FRAME_W-1 -: WORD_W] = encode_word(PT_CONTROL, status);
        for (int i = 0; i < RESULT_BYTES; i++) begin
            build_frame[FRAME_W-1-WORD_W*(i+1) -: WORD_W] = encode_word(PT_DATA, res[RW-1-8*i -: 8]);
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        par_err_d    = par_err_q;
        cnt_err_d    = cnt_err_q;
        op_d         = op_q;
        status_d     = status_q;
        acc_d        = acc_q;
        tx_d         = tx_q;
        tx_cnt_d     = tx_cnt_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        buf_we       = 1'b0;
        load_tx      = 1'b0;
        acc_next     = fold(acc_q, buffer_q[idx_q[IDX_W-1:0]], op_q);
        result       = acc_next;

        case (state_q)
            S_IDLE: begin
                count_d   = '0;
                par_err_d = 1'b0;
                cnt_err_d = 1'b0;
                if (!enable_n) state_d = S_RECV;
            end
            S_RECV: begin
                // A finished control word wins over enable_n rising on the same edge.
                if (rx_valid && (rx_type == PT_CONTROL)) begin
                    op_d                  = rx_byte;
                    status_d              = '0;
                    status_d[STAT_INVALID] = !op_valid(rx_byte);
                    status_d[STAT_PARITY]  = par_err_q || !rx_parity_ok;
                    status_d[STAT_COUNT]   = cnt_err_q || (count_q < CNT_W'(2));
                    acc_d                 = RW'(buffer_q[0]);
                    idx_d                 = CNT_W'(1);
                    state_d               = S_COMPUTE;
                end else if (enable_n) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    par_err_d = par_err_q || !rx_parity_ok;
                    if (count_q == CNT_W'(MAX_OPERANDS)) begin
                        cnt_err_d = 1'b1;
                    end else begin
                        buf_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (status_q != 8'h00) begin
                    result  = '0;
                    load_tx = 1'b1;
                end else begin
                    acc_d = acc_next;
                    idx_d = idx_q + CNT_W'(1);
                    if ((idx_q + CNT_W'(1)) == count_q) load_tx = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_cnt_q == TXC_W'(FRAME_W)) begin
                    state_d = S_IDLE;
                end else begin
                    dout_d       = tx_q[FRAME_W-1];
                    dout_valid_d = 1'b1;
                    tx_d         = {tx_q[FRAME_W-2:0], 1'b0};
                    tx_cnt_d     = tx_cnt_q + TXC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame = build_frame(status_q, result);
        if (load_tx) begin
            dout_d       = frame[FRAME_W-1];
            dout_valid_d = 1'b1;
            tx_d         = {frame[FRAME_W-2:0], 1'b0};
            tx_cnt_d     = TXC_W'(1);
            state_d      = S_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            par_err_q    <= 1'b0;
            cnt_err_q    <= 1'b0;
            op_q         <= '0;
            status_q     <= '0;
            acc_q        <= '0;
            tx_q         <= '0;
            tx_cnt_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            par_err_q    <= par_err_d;
            cnt_err_q    <= cnt_err_d;
            op_q         <= op_d;
            status_q     <= status_d;
            acc_q        <= acc_d;
            tx_q         <= tx_d;
            tx_cnt_q     <= tx_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // NOTE: the operand buffer has no reset; entries are only read after the
    // current frame has written them, so clearing storage would be wasted logic.
    always_ff @(posedge clk) begin
        if (buf_we) buffer_q[count_q[IDX_W-1:0]] <= rx_byte;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
